adc_capture_fifo: RTL and testbench
===================================

# adc_capture_fifo

Upstream feeder for the bus-side ADC read decoder: captures one frame of `DEPTH` 12-bit samples from one parallel ADC channel into an internal FIFO. It presents the head word plus a non-empty flag, and pops one word per bus read strobe from the STM32. The design instantiates it twice, once per ADC channel. Its outputs drive the decoder's `FIFO_DATA_IN` and `FLAG` inputs.

## Interface
- `DATA_W`, default 12: sample width.
- `DEPTH`, default 1024: frame length in samples; must be a power of two.
- `AW`, default 10: address width, equal to log2(`DEPTH`).
- `CLK`, input, 1: system clock, all logic on the rising edge.
- `RST_N`, input, 1: asynchronous active-low reset.
- `ADC_DATA`, input, `DATA_W`: ADC parallel output, natural bit order, sampled only when `ADC_VALID`=1.
- `ADC_VALID`, input, 1: one-cycle sample strobe from the sample-rate divider.
- `START`, input, 1: one-cycle pulse; flushes the FIFO and arms a new frame.
- `RD_EN`, input, 1: bus read strobe, asynchronous to `CLK`; each rising edge pops one word.
- `FIFO_DATA_OUT`, output, `DATA_W`: head-of-FIFO word, natural bit order.
- `FIFO_FLAG`, output, 1: 1 when the FIFO is non-empty.
- `BUSY`, output, 1: 1 in any state except IDLE.
- `SAMPLE_CNT`, output, `AW`+1: samples written in the current frame.
- `TRIG_LEVEL`, input, `DATA_W`: trigger threshold, unsigned. Present only with `ADC_CAPTURE_TRIG_EN`.

## Operation
- States and transitions:
  - IDLE: no writes. `START` → ARM.
  - ARM: waits for the trigger (see Configuration). Trigger → CAPTURE.
  - CAPTURE: writes `ADC_DATA` on every `ADC_VALID`. The write that makes `SAMPLE_CNT`=`DEPTH` → DRAIN.
  - DRAIN: no writes. FIFO empty → IDLE.
- `START` in any state:
  - clears the read pointer, write pointer, count and `SAMPLE_CNT`;
  - discards the FIFO contents;
  - moves to ARM on the next edge.
  - `START` and `ADC_VALID` in the same cycle: that sample is not written.
- Storage:
  - `DEPTH`×`DATA_W` dual-port RAM with one synchronous write port and one synchronous read port.
  - Pointers are `AW` bits and wrap modulo `DEPTH`.
  - Occupancy count is `AW`+1 bits, range 0..`DEPTH`.
- Read path:
  - `RD_EN` passes through a 2-flop synchronizer, then a rising-edge detector, producing a one-cycle `pop`.
  - `pop` with FIFO empty is ignored: pointers and count unchanged.
  - Write and `pop` in the same cycle: both pointers advance and the count is unchanged.
- Overflow is impossible: writes per frame are capped at `DEPTH` by `SAMPLE_CNT`, independent of pops.
- `FIFO_DATA_OUT` is show-ahead:
  - it holds the head word whenever `FIFO_FLAG`=1;
  - it holds its last value when the FIFO is empty.

## Timing
- Reset values:
  - state IDLE;
  - pointers, count and `SAMPLE_CNT` 0;
  - `FIFO_DATA_OUT` 0, `FIFO_FLAG` 0, `BUSY` 0;
  - synchronizer flops 0.
- Write latency: a sample accepted at edge N gives `FIFO_FLAG`=1 and a valid `FIFO_DATA_OUT` after edge N+2, when the FIFO was empty.
- Pop latency:
  - an `RD_EN` rise is seen as `pop` 2–3 cycles later;
  - `FIFO_DATA_OUT` shows the next word 2 cycles after `pop`;
  - minimum bus read spacing is therefore 6 `CLK` cycles.
- `FIFO_FLAG` falls in the cycle after the `pop` that empties the FIFO.
- DRAIN→IDLE: on the edge after the count reaches 0; `BUSY` falls on that same edge.
- `RST_N` asserted mid-frame: all outputs go to their reset values immediately, without waiting for a clock edge. The RAM contents are don't-care.

## Configuration
- Macro: `ADC_CAPTURE_TRIG_EN`.
- With the macro defined:
  - ARM keeps the previous valid sample.
  - It triggers on the first `ADC_VALID` where previous < `TRIG_LEVEL` ≤ current, as an unsigned compare.
  - The triggering sample is the first one written.
- Without the macro:
  - ARM lasts exactly one cycle, then moves to CAPTURE;
  - the `TRIG_LEVEL` port is absent.

## Structure
- Shared package holds:
  - the state encoding `adc_cap_state_t` (IDLE, ARM, CAPTURE, DRAIN);
  - `ADC_DATA_W` = 12;
  - `ADC_FRAME_DEPTH` = 1024.
- One sub-module, `sync_fifo_ram`: simple dual-port RAM with a registered read.
- Synchronizer, edge detector, pointers and state machine stay in the top module.

## Test plan
- Reset, then `START`, then 1024 strobes with `ADC_DATA`=0..1023 and no reads → `SAMPLE_CNT`=1024, state DRAIN, `FIFO_FLAG`=1, `FIFO_DATA_OUT`=0.
- Frame full, then 1024 `RD_EN` pulses spaced 8 cycles → words read 0..1023 in order. `FIFO_FLAG` falls after the last pop; `BUSY` falls one cycle later.
- Empty FIFO during CAPTURE, 3 extra `RD_EN` pulses → no pointer change, `FIFO_DATA_OUT` holds its last value. Read and write landing on the same edge → count unchanged.
- `START` at sample 500 → count 0, `FIFO_FLAG`=0. The new frame's first word is the next sample after ARM.
- `RST_N` low at sample 300 → all outputs 0 immediately. `START` after release → normal capture from sample 0.
- With `ADC_CAPTURE_TRIG_EN` and `TRIG_LEVEL`=2048, a ramp 2000, 2040, 2050, ... → first stored word 2050.

Source files
------------

// File: rtl/adc_capture_fifo_pkg.sv
// adc_capture_fifo_pkg
//   Shared definitions for the ADC frame-capture FIFO: capture state encoding
//   and the default sample width / frame depth used by the top module.
package adc_capture_fifo_pkg;

    localparam int ADC_DATA_W      = 12;
    localparam int ADC_FRAME_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } adc_cap_state_t;

endpackage

// File: rtl/adc_capture_fifo_ram.sv
// sync_fifo_ram
//   Simple dual-port RAM backing the capture FIFO. One synchronous write port,
//   one synchronous (registered) read port. A read of the address being
//   written on the same edge returns the old contents.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address, sampled every edge
//   rdata  - registered read data
module sync_fifo_ram #(
    parameter int DATA_W = 12,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/adc_capture_fifo.sv
// adc_capture_fifo
//   Captures one frame of DEPTH samples from a parallel ADC into a FIFO and
//   presents the head word (show-ahead) plus a non-empty flag to the bus-side
//   read decoder. Each rising edge of the asynchronous bus read strobe pops
//   one word.
// Optional feature macro: ADC_CAPTURE_TRIG_EN
//   Defined   - ARM waits for a rising crossing of TRIG_LEVEL (previous <
//               TRIG_LEVEL <= current, unsigned); the crossing sample is the
//               first word written. Adds the TRIG_LEVEL port.
//   Undefined - ARM lasts one cycle, then CAPTURE.
// Ports:
//   CLK, RST_N     - clock (rising edge), async active-low reset
//   ADC_DATA       - sample, taken when ADC_VALID=1 in CAPTURE
//   ADC_VALID      - one-cycle sample strobe
//   START          - flush FIFO and arm a new frame
//   RD_EN          - async bus read strobe, rising edge pops one word
//   TRIG_LEVEL     - trigger threshold (trigger build only)
//   FIFO_DATA_OUT  - head-of-FIFO word, held when empty
//   FIFO_FLAG      - FIFO non-empty
//   BUSY           - state is not IDLE
//   SAMPLE_CNT     - samples written in the current frame
module adc_capture_fifo
    import adc_capture_fifo_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int DEPTH  = ADC_FRAME_DEPTH,
    parameter int AW     = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] ADC_DATA,
    input  logic              ADC_VALID,
    input  logic              START,
    input  logic              RD_EN,
`ifdef ADC_CAPTURE_TRIG_EN
    input  logic [DATA_W-1:0] TRIG_LEVEL,
`endif
    output logic [DATA_W-1:0] FIFO_DATA_OUT,
    output logic              FIFO_FLAG,
    output logic              BUSY,
    output logic [AW:0]       SAMPLE_CNT
);

    localparam logic [AW:0] LAST_SAMPLE = (AW+1)'(DEPTH - 1);

    adc_cap_state_t    state;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_nxt;
    logic              rd_s1, rd_s2, rd_s3;
    logic              pop, pop_ok, wr_en;
    logic              arm_wr, arm_exit;
    logic              ne_d1;
    logic [DATA_W-1:0] rd_q;

    // ---------------------------------------------------------------- trigger
`ifdef ADC_CAPTURE_TRIG_EN
    logic [DATA_W-1:0] prev_sample;
    logic              prev_vld;
    logic              trig_hit;

    // A crossing needs a real previous sample; the first strobe after START
    // only seeds prev_sample.
    assign trig_hit = ADC_VALID && prev_vld &&
                      (prev_sample < TRIG_LEVEL) && (TRIG_LEVEL <= ADC_DATA);
    assign arm_wr   = trig_hit;
    assign arm_exit = trig_hit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_sample <= '0;
            prev_vld    <= 1'b0;
        end else if (START) begin
            prev_vld    <= 1'b0;
        end else if (state == ARM && ADC_VALID) begin
            prev_sample <= ADC_DATA;
            prev_vld    <= 1'b1;
        end
    end
`else
    assign arm_wr   = 1'b0;
    assign arm_exit = 1'b1;
`endif

    // ------------------------------------------------------ read synchronizer
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_s1 <= 1'b0;
            rd_s2 <= 1'b0;
            rd_s3 <= 1'b0;
        end else begin
            rd_s1 <= RD_EN;
            rd_s2 <= rd_s1;
            rd_s3 <= rd_s2;
        end
    end

    assign pop    = rd_s2 & ~rd_s3;
    assign pop_ok = pop && (count != '0);

    // Sample written only while capturing (or on the trigger sample); START
    // wins over a coincident strobe.
    assign wr_en = !START && ADC_VALID &&
                   ((state == CAPTURE) || (state == ARM && arm_wr));

    always_comb begin
        count_nxt = count;
        case ({wr_en, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // --------------------------------------------------------- state machine
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            BUSY  <= 1'b0;
        end else if (START) begin
            state <= ARM;
            BUSY  <= 1'b1;
        end else begin
            case (state)
                IDLE: BUSY <= 1'b0;
                ARM: begin
                    if (arm_exit) state <= CAPTURE;
                end
                CAPTURE: begin
                    if (wr_en && SAMPLE_CNT == LAST_SAMPLE) state <= DRAIN;
                end
                DRAIN: begin
                    if (count == '0) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------- pointers and counters
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            SAMPLE_CNT <= '0;
        end else if (START) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            SAMPLE_CNT <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr     <= wr_ptr + 1'b1;
                SAMPLE_CNT <= SAMPLE_CNT + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk   (CLK),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (ADC_DATA),
        .raddr (rd_ptr),
        .rdata (rd_q)
    );

    // ----------------------------------------------------- show-ahead output
    // rd_q is a valid head word only if the FIFO was non-empty when it was
    // read (ne_d1). The flag rises once both that and the current count agree
    // (so a refill right after emptying waits for fresh RAM data) and falls
    // immediately on the pop that empties the FIFO.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ne_d1         <= 1'b0;
            FIFO_FLAG     <= 1'b0;
            FIFO_DATA_OUT <= '0;
        end else if (START) begin
            ne_d1         <= 1'b0;
            FIFO_FLAG     <= 1'b0;
        end else begin
            ne_d1     <= (count != '0);
            FIFO_FLAG <= ne_d1 && (count != '0) && (count_nxt != '0);
            if (ne_d1) FIFO_DATA_OUT <= rd_q;
        end
    end

endmodule

// File: tb/tb_adc_capture_fifo.sv
// tb_adc_capture_fifo
//   Directed bench for adc_capture_fifo: full frame capture, ordered drain,
//   empty pops, coincident read/write, restart mid-frame, async reset and
//   (with ADC_CAPTURE_TRIG_EN) the level trigger.
module tb_adc_capture_fifo;
    import adc_capture_fifo_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic [11:0] ADC_DATA;
    logic        ADC_VALID;
    logic        START;
    logic        RD_EN;
`ifdef ADC_CAPTURE_TRIG_EN
    logic [11:0] TRIG_LEVEL;
`endif
    logic [11:0] FIFO_DATA_OUT;
    logic        FIFO_FLAG;
    logic        BUSY;
    logic [10:0] SAMPLE_CNT;

    int n_assert = 0;
    int n_fail   = 0;

    adc_capture_fifo dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .ADC_DATA      (ADC_DATA),
        .ADC_VALID     (ADC_VALID),
        .START         (START),
        .RD_EN         (RD_EN),
`ifdef ADC_CAPTURE_TRIG_EN
        .TRIG_LEVEL    (TRIG_LEVEL),
`endif
        .FIFO_DATA_OUT (FIFO_DATA_OUT),
        .FIFO_FLAG     (FIFO_FLAG),
        .BUSY          (BUSY),
        .SAMPLE_CNT    (SAMPLE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs are driven and outputs sampled 1ns later.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic strobe(input logic [11:0] d);
        ADC_DATA  = d;
        ADC_VALID = 1'b1;
        tick();
        ADC_VALID = 1'b0;
    endtask

    task automatic rd_pulse();
        RD_EN = 1'b1;
        tick(4);
        RD_EN = 1'b0;
        tick(4);
    endtask

    task automatic do_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    initial begin
        int bad;
        RST_N     = 1'b0;
        ADC_DATA  = '0;
        ADC_VALID = 1'b0;
        START     = 1'b0;
        RD_EN     = 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
        TRIG_LEVEL = 12'd0;
`endif
        #1;
        tick(3);
        chk("rst_dout", FIFO_DATA_OUT, 0);
        chk("rst_flag", FIFO_FLAG, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_cnt",  SAMPLE_CNT, 0);
        RST_N = 1'b1;
        tick(2);

`ifndef ADC_CAPTURE_TRIG_EN
        // ---- full frame 0..1023, no reads
        do_start();
        chk("start_busy", BUSY, 1);
        tick();                        // ARM -> CAPTURE
        for (int i = 0; i < 1024; i++) begin
            strobe(12'(i));
            if (i == 1) chk("wlat_flag_n1", FIFO_FLAG, 0);
            if (i == 2) begin
                chk("wlat_flag_n2", FIFO_FLAG, 1);
                chk("wlat_dout_n2", FIFO_DATA_OUT, 0);
            end
        end
        tick(2);
        chk("full_cnt",   SAMPLE_CNT, 1024);
        chk("full_state", dut.state, DRAIN);
        chk("full_flag",  FIFO_FLAG, 1);
        chk("full_dout",  FIFO_DATA_OUT, 0);

        // ---- drain in order
        bad = 0;
        for (int i = 0; i < 1023; i++) begin
            if (FIFO_DATA_OUT !== 12'(i) || FIFO_FLAG !== 1'b1) bad++;
            rd_pulse();
        end
        chk("drain_order", bad, 0);
        chk("drain_last_word", FIFO_DATA_OUT, 1023);
        RD_EN = 1'b1;
        tick(2);
        chk("last_flag_pre", FIFO_FLAG, 1);
        tick();                        // pop lands here
        chk("last_flag_fall", FIFO_FLAG, 0);
        chk("last_busy_hold", BUSY, 1);
        tick();
        chk("last_busy_fall", BUSY, 0);
        RD_EN = 1'b0;
        tick(4);
        chk("empty_dout_hold", FIFO_DATA_OUT, 1023);

        // ---- empty pops during CAPTURE, coincident read/write
        do_start();
        tick();
        strobe(12'd100);
        tick(3);
        chk("cap_dout_100", FIFO_DATA_OUT, 100);
        rd_pulse();
        chk("cap_empty_flag", FIFO_FLAG, 0);
        for (int i = 0; i < 3; i++) rd_pulse();
        chk("empty_pop_rdptr", dut.rd_ptr, 1);
        chk("empty_pop_count", dut.count, 0);
        chk("empty_pop_dout",  FIFO_DATA_OUT, 100);
        strobe(12'd101);
        tick(3);
        chk("cap_dout_101", FIFO_DATA_OUT, 101);
        RD_EN = 1'b1;
        tick(2);
        ADC_DATA  = 12'd102;
        ADC_VALID = 1'b1;
        tick();                        // pop and write on the same edge
        ADC_VALID = 1'b0;
        chk("rw_count",  dut.count, 1);
        chk("rw_wrptr",  dut.wr_ptr, 3);
        chk("rw_rdptr",  dut.rd_ptr, 2);
        tick(3);
        RD_EN = 1'b0;
        chk("rw_dout", FIFO_DATA_OUT, 102);
        chk("rw_flag", FIFO_FLAG, 1);

        // ---- restart at sample 500
        do_start();
        tick();
        for (int i = 0; i < 500; i++) strobe(12'(i));
        chk("pre_restart_cnt", SAMPLE_CNT, 500);
        ADC_DATA  = 12'd777;
        ADC_VALID = 1'b1;
        START     = 1'b1;
        tick();
        START     = 1'b0;
        ADC_VALID = 1'b0;
        chk("restart_cnt",   SAMPLE_CNT, 0);
        chk("restart_count", dut.count, 0);
        chk("restart_flag",  FIFO_FLAG, 0);
        chk("restart_busy",  BUSY, 1);
        strobe(12'd554);               // lands in ARM, dropped
        strobe(12'd555);
        tick(3);
        chk("restart_first",  FIFO_DATA_OUT, 555);
        chk("restart_cnt1",   SAMPLE_CNT, 1);

        // ---- async reset mid-frame
        do_start();
        tick();
        for (int i = 0; i < 300; i++) strobe(12'(i + 1000));
        RST_N = 1'b0;
        #1;
        chk("arst_dout", FIFO_DATA_OUT, 0);
        chk("arst_flag", FIFO_FLAG, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_cnt",  SAMPLE_CNT, 0);
        tick(2);
        RST_N = 1'b1;
        tick();
        do_start();
        tick();
        for (int i = 0; i < 5; i++) strobe(12'(i));
        tick(2);
        chk("post_rst_dout", FIFO_DATA_OUT, 0);
        chk("post_rst_cnt",  SAMPLE_CNT, 5);
        chk("post_rst_flag", FIFO_FLAG, 1);
`else
        // ---- level trigger on a ramp
        TRIG_LEVEL = 12'd2048;
        do_start();
        tick();
        chk("trig_cnt0", SAMPLE_CNT, 0);
        strobe(12'd2000);
        strobe(12'd2040);
        chk("trig_not_yet", SAMPLE_CNT, 0);
        chk("trig_armed", dut.state, ARM);
        strobe(12'd2050);
        strobe(12'd2060);
        tick(3);
        chk("trig_first", FIFO_DATA_OUT, 2050);
        chk("trig_cnt2",  SAMPLE_CNT, 2);
        chk("trig_flag",  FIFO_FLAG, 1);
        chk("trig_busy",  BUSY, 1);
        rd_pulse();
        chk("trig_second", FIFO_DATA_OUT, 2060);
        rd_pulse();
        chk("trig_empty", FIFO_FLAG, 0);
        do_start();
        tick();
        strobe(12'd3000);              // above level but no prior sample
        strobe(12'd100);
        strobe(12'd2048);              // 100 < 2048 <= 2048
        tick(3);
        chk("trig_eq_first", FIFO_DATA_OUT, 2048);
        chk("trig_eq_cnt",   SAMPLE_CNT, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
